// File: rtl/decode_queue_wide_if.sv
// Shared types and the fetch/decode/rename handshake bundle for decode_queue_wide.
// Machine-width and PHT-size macros can be predefined by the including build; these are fallbacks.

`ifndef M_WIDTH
`define M_WIDTH 32
`endif
`ifndef LG_PHT_SZ
`define LG_PHT_SZ 10
`endif

package decode_queue_wide_pkg;

  localparam int M_WIDTH   = `M_WIDTH;
  localparam int LG_PHT_SZ = `LG_PHT_SZ;
  localparam int LG_ROB    = 6;

  // Coarse operation class produced by the per-instruction decoder.
  typedef enum logic [3:0] {
    U_ILLEGAL = 4'd0,
    U_ALU_RR  = 4'd1,
    U_ALU_RI  = 4'd2,
    U_LUI     = 4'd3,
    U_AUIPC   = 4'd4,
    U_JAL     = 4'd5,
    U_JALR    = 4'd6,
    U_BRANCH  = 4'd7,
    U_LOAD    = 4'd8,
    U_STORE   = 4'd9,
    U_FENCE   = 4'd10,
    U_SYSTEM  = 4'd11
  } uop_class_e;

  typedef struct packed {
    uop_class_e           op;
    logic [2:0]           funct3;
    logic                 funct7b5;
    logic [4:0]           srcA;
    logic                 srcAValid;
    logic [4:0]           srcB;
    logic                 srcBValid;
    logic [4:0]           dst;
    logic                 dstValid;
    logic [31:0]          imm;
    logic [M_WIDTH-1:0]   pc;
    logic [M_WIDTH-1:0]   jmp_target;
    logic                 is_br;
    logic                 br_pred;
    logic [LG_PHT_SZ-1:0] pht_idx;
    logic                 serializing_op;
    logic [LG_ROB-1:0]    rob_ptr;
  } uop_t;

  // One queued fetch packet, kept raw so decode happens at the queue head.
  typedef struct packed {
    logic [31:0]          insn;
    logic [M_WIDTH-1:0]   pc;
    logic                 pred;
    logic [LG_PHT_SZ-1:0] phtIdx;
    logic [M_WIDTH-1:0]   predTarget;
  } entry_t;

endpackage

interface decode_queue_wide_if #(
  parameter int W    = 2,
  parameter int LG_Q = 3
);
  import decode_queue_wide_pkg::*;

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_insn;
  logic [M_WIDTH-1:0]   in_pc;
  logic                 in_pred;
  logic [LG_PHT_SZ-1:0] in_pht_idx;
  logic [M_WIDTH-1:0]   in_pred_target;
  logic [W-1:0]         out_valid;
  uop_t [W-1:0]         out_uop;
  logic                 out_ready;
  logic [LG_Q:0]        count;

  // Fetch/rename side drives the requests and consumes the decoded bundle.
  modport master (
    output flush, in_valid, in_insn, in_pc, in_pred, in_pht_idx, in_pred_target, out_ready,
    input  in_ready, out_valid, out_uop, count
  );

  // The queue itself.
  modport slave (
    input  flush, in_valid, in_insn, in_pc, in_pred, in_pht_idx, in_pred_target, out_ready,
    output in_ready, out_valid, out_uop, count
  );

endinterface

// File: rtl/decode_queue_wide.sv
// Circular fetch queue with W parallel RISC-V decoders at its head, forming in-order
// bundles for rename. Serializing ops issue alone in lane 0; a branch closes the bundle.
// Requires LG_Q >= 1 and 1 <= W <= 2**LG_Q.

module decode_riscv
  import decode_queue_wide_pkg::*;
(
  input  logic [31:0]          insn_i,
  input  logic [M_WIDTH-1:0]   pc_i,
  input  logic                 pred_i,
  input  logic [LG_PHT_SZ-1:0] phtIdx_i,
  input  logic [M_WIDTH-1:0]   predTarget_i,
  output uop_t                 uop_o
);

  logic [6:0]  opcode;
  logic [31:0] immI;
  logic [31:0] immS;
  logic [31:0] immB;
  logic [31:0] immU;
  logic [31:0] immJ;

  assign opcode = insn_i[6:0];
  assign immI   = {{20{insn_i[31]}}, insn_i[31:20]};
  assign immS   = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
  assign immB   = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
  assign immU   = {insn_i[31:12], 12'b0};
  assign immJ   = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};

  // Classify the instruction and fill in operands, immediate and control-flow metadata.
  always_comb begin
    uop_o                = '0;
    uop_o.op             = U_ILLEGAL;
    uop_o.funct3         = insn_i[14:12];
    uop_o.funct7b5       = insn_i[30];
    uop_o.srcA           = insn_i[19:15];
    uop_o.srcB           = insn_i[24:20];
    uop_o.dst            = insn_i[11:7];
    uop_o.pc             = pc_i;
    uop_o.br_pred        = pred_i;
    uop_o.pht_idx        = phtIdx_i;
    uop_o.jmp_target     = pc_i;
    uop_o.rob_ptr        = '0;
    if (insn_i[1:0] != 2'b11) begin
      uop_o.serializing_op = 1'b1;
    end else begin
      unique case (opcode)
        7'h33: begin
          uop_o.op        = U_ALU_RR;
          uop_o.srcAValid = 1'b1;
          uop_o.srcBValid = 1'b1;
          uop_o.dstValid  = 1'b1;
        end
        7'h13: begin
          uop_o.op        = U_ALU_RI;
          uop_o.srcAValid = 1'b1;
          uop_o.dstValid  = 1'b1;
          uop_o.imm       = immI;
        end
        7'h37: begin
          uop_o.op       = U_LUI;
          uop_o.dstValid = 1'b1;
          uop_o.imm      = immU;
        end
        7'h17: begin
          uop_o.op       = U_AUIPC;
          uop_o.dstValid = 1'b1;
          uop_o.imm      = immU;
        end
        7'h6f: begin
          uop_o.op         = U_JAL;
          uop_o.dstValid   = 1'b1;
          uop_o.imm        = immJ;
          uop_o.is_br      = 1'b1;
          uop_o.jmp_target = pc_i + M_WIDTH'($signed(immJ));
        end
        7'h67: begin
          uop_o.op         = U_JALR;
          uop_o.srcAValid  = 1'b1;
          uop_o.dstValid   = 1'b1;
          uop_o.imm        = immI;
          uop_o.is_br      = 1'b1;
          uop_o.jmp_target = predTarget_i;
        end
        7'h63: begin
          uop_o.op         = U_BRANCH;
          uop_o.srcAValid  = 1'b1;
          uop_o.srcBValid  = 1'b1;
          uop_o.imm        = immB;
          uop_o.is_br      = 1'b1;
          uop_o.jmp_target = pc_i + M_WIDTH'($signed(immB));
        end
        7'h03: begin
          uop_o.op        = U_LOAD;
          uop_o.srcAValid = 1'b1;
          uop_o.dstValid  = 1'b1;
          uop_o.imm       = immI;
        end
        7'h23: begin
          uop_o.op        = U_STORE;
          uop_o.srcAValid = 1'b1;
          uop_o.srcBValid = 1'b1;
          uop_o.imm       = immS;
        end
        7'h0f: begin
          uop_o.op             = U_FENCE;
          uop_o.serializing_op = 1'b1;
        end
        7'h73: begin
          uop_o.op             = U_SYSTEM;
          uop_o.srcAValid      = 1'b1;
          uop_o.dstValid       = 1'b1;
          uop_o.imm            = immI;
          uop_o.serializing_op = 1'b1;
        end
        default: begin
          uop_o.serializing_op = 1'b1;
        end
      endcase
    end
  end

endmodule

module decode_queue_wide
  import decode_queue_wide_pkg::*;
#(
  parameter int W    = 2,
  parameter int LG_Q = 3
) (
  input logic               clk,
  input logic               reset,
  decode_queue_wide_if.slave bus
);

  localparam int Q = 2 ** LG_Q;
  localparam logic [LG_Q:0] QCNT = (LG_Q + 1)'(Q);

  entry_t          mem_q [Q];
  logic [LG_Q-1:0] head_q;
  logic [LG_Q-1:0] head_d;
  logic [LG_Q-1:0] tail_q;
  logic [LG_Q-1:0] tail_d;
  logic [LG_Q:0]   count_q;
  logic [LG_Q:0]   count_d;

  uop_t            laneUop [W];
  logic [W-1:0]    laneValid;
  logic [LG_Q:0]   popCnt;
  logic            doPush;
  logic            doPop;
  logic            blockRest;

  assign bus.in_ready = (count_q != QCNT);
  assign bus.count    = count_q;
  assign doPush       = bus.in_valid & bus.in_ready & ~bus.flush;
  assign doPop        = bus.out_ready & laneValid[0] & ~bus.flush;

  // One decoder per lane, reading the entry k slots past the head; pointer math wraps mod Q.
  for (genvar k = 0; k < W; k++) begin : gLane
    logic [LG_Q-1:0] idx;
    assign idx = head_q + LG_Q'(k);
    decode_riscv uDecode (
      .insn_i       (mem_q[idx].insn),
      .pc_i         (mem_q[idx].pc),
      .pred_i       (mem_q[idx].pred),
      .phtIdx_i     (mem_q[idx].phtIdx),
      .predTarget_i (mem_q[idx].predTarget),
      .uop_o        (laneUop[k])
    );
  end

  // Build the contiguous valid prefix: stop at empty slots, keep serializing ops alone, end on a branch.
  always_comb begin
    laneValid = '0;
    blockRest = 1'b0;
    popCnt    = '0;
    for (int k = 0; k < W; k++) begin
      if (!blockRest && (count_q > (LG_Q + 1)'(k)) && !(k > 0 && laneUop[k].serializing_op)) begin
        laneValid[k] = 1'b1;
        popCnt       = popCnt + 1'b1;
        if (laneUop[k].serializing_op || laneUop[k].is_br) begin
          blockRest = 1'b1;
        end
      end else begin
        blockRest = 1'b1;
      end
    end
  end

  // Present the decoded bundle; invalid lanes still carry (stale, X-free) decoded data.
  always_comb begin
    bus.out_valid = laneValid;
    bus.out_uop   = '0;
    for (int k = 0; k < W; k++) begin
      bus.out_uop[k] = laneUop[k];
    end
  end

  // Next-state pointers and occupancy; flush wins over both push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (doPush) begin
        tail_d = tail_q + 1'b1;
      end
      if (doPop) begin
        head_d = head_q + popCnt[LG_Q-1:0];
      end
      count_d = count_q + (LG_Q + 1)'(doPush) - (doPop ? popCnt : '0);
    end
  end

  // Pointer and occupancy registers; reset empties the queue just like a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; cleared on reset so never-written slots decode to known values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Q; i++) begin
        mem_q[i] <= '0;
      end
    end else if (doPush) begin
      mem_q[tail_q] <= '{insn:       bus.in_insn,
                         pc:         bus.in_pc,
                         pred:       bus.in_pred,
                         phtIdx:     bus.in_pht_idx,
                         predTarget: bus.in_pred_target};
    end
  end

  countBound: assert property (@(posedge clk) disable iff (reset) count_q <= QCNT);

endmodule

// File: tb/tb_decode_queue_wide.sv
// Directed bench for decode_queue_wide (W=2, Q=8) with hand-computed expectations.

module tb_decode_queue_wide;
  import decode_queue_wide_pkg::*;

  localparam logic [31:0] ADDI1 = 32'h0010_0093;
  localparam logic [31:0] ADDI2 = 32'h0020_0113;
  localparam logic [31:0] ADDI3 = 32'h0030_0193;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] BEQ8  = 32'h0000_0463;

  logic clk;
  logic reset;
  int   checkCount;
  int   failCount;

  decode_queue_wide_if #(.W(2), .LG_Q(3)) bus ();

  decode_queue_wide #(.W(2), .LG_Q(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock once, then return all strobes to idle.
  task automatic applyStimulus(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                               input logic pred, input logic outRdy, input logic fl, input logic rst);
    bus.in_valid       = v;
    bus.in_insn        = insn;
    bus.in_pc          = M_WIDTH'(pc);
    bus.in_pred        = pred;
    bus.in_pht_idx     = LG_PHT_SZ'(pc >> 2);
    bus.in_pred_target = M_WIDTH'(32'h0000_8000);
    bus.out_ready      = outRdy;
    bus.flush          = fl;
    reset              = rst;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    reset         = 1'b0;
  endtask

  task automatic pushInsn(input logic [31:0] insn, input logic [31:0] pc, input logic pred);
    applyStimulus(1'b1, insn, pc, pred, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popBundle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    reset      = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_insn  = '0;
    bus.in_pc    = '0;
    bus.in_pred  = 1'b0;
    bus.in_pht_idx = '0;
    bus.in_pred_target = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    checkOutput("reset count", 64'(bus.count), 64'd0);
    checkOutput("reset in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);

    // Three ALU ops held back: two-lane bundle ready.
    pushInsn(ADDI1, 32'h100, 1'b0);
    checkOutput("no bypass", 64'(bus.out_valid), 64'b01);
    pushInsn(ADDI2, 32'h104, 1'b0);
    pushInsn(ADDI3, 32'h108, 1'b0);
    checkOutput("alu count", 64'(bus.count), 64'd3);
    checkOutput("alu valid", 64'(bus.out_valid), 64'b11);
    checkOutput("alu lane0 pc", 64'(bus.out_uop[0].pc), 64'h100);
    checkOutput("alu lane1 pc", 64'(bus.out_uop[1].pc), 64'h104);
    checkOutput("alu lane0 dst", 64'(bus.out_uop[0].dst), 64'd1);
    checkOutput("alu lane1 imm", 64'(bus.out_uop[1].imm), 64'd2);
    checkOutput("alu rob_ptr", 64'(bus.out_uop[0].rob_ptr), 64'd0);
    popBundle();
    checkOutput("pop2 count", 64'(bus.count), 64'd1);
    checkOutput("pop2 lane0 pc", 64'(bus.out_uop[0].pc), 64'h108);
    checkOutput("pop2 valid", 64'(bus.out_valid), 64'b01);
    popBundle();
    checkOutput("drain1 count", 64'(bus.count), 64'd0);

    // Serializing op must issue alone in lane 0.
    pushInsn(ADDI1, 32'h200, 1'b0);
    pushInsn(ECALL, 32'h204, 1'b0);
    pushInsn(ADDI2, 32'h208, 1'b0);
    checkOutput("ser pre valid", 64'(bus.out_valid), 64'b01);
    checkOutput("ser pre pc", 64'(bus.out_uop[0].pc), 64'h200);
    popBundle();
    checkOutput("ser valid", 64'(bus.out_valid), 64'b01);
    checkOutput("ser lane0 pc", 64'(bus.out_uop[0].pc), 64'h204);
    checkOutput("ser flag", 64'(bus.out_uop[0].serializing_op), 64'd1);
    popBundle();
    checkOutput("post ser pc", 64'(bus.out_uop[0].pc), 64'h208);
    checkOutput("post ser count", 64'(bus.count), 64'd1);
    popBundle();

    // Branch closes the bundle; prediction bit carried through.
    pushInsn(BEQ8, 32'h300, 1'b1);
    pushInsn(ADDI3, 32'h304, 1'b0);
    checkOutput("br valid", 64'(bus.out_valid), 64'b01);
    checkOutput("br is_br", 64'(bus.out_uop[0].is_br), 64'd1);
    checkOutput("br pred", 64'(bus.out_uop[0].br_pred), 64'd1);
    checkOutput("br imm", 64'(bus.out_uop[0].imm), 64'd8);
    checkOutput("br target", 64'(bus.out_uop[0].jmp_target), 64'h308);
    popBundle();
    checkOutput("after br pc", 64'(bus.out_uop[0].pc), 64'h304);
    checkOutput("after br valid", 64'(bus.out_valid), 64'b01);
    popBundle();
    checkOutput("drain3 count", 64'(bus.count), 64'd0);

    // Fill to full, refused pushes, then wrap the tail.
    for (int i = 0; i < 8; i++) begin
      pushInsn(ADDI1, 32'h400 + 32'(i * 4), 1'b0);
    end
    checkOutput("full count", 64'(bus.count), 64'd8);
    checkOutput("full in_ready", 64'(bus.in_ready), 64'd0);
    pushInsn(ADDI1, 32'h420, 1'b0);
    checkOutput("refused count", 64'(bus.count), 64'd8);
    applyStimulus(1'b1, ADDI1, 32'h420, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("full pop count", 64'(bus.count), 64'd6);
    checkOutput("full pop pc", 64'(bus.out_uop[0].pc), 64'h408);
    pushInsn(ADDI1, 32'h424, 1'b0);
    checkOutput("wrap count", 64'(bus.count), 64'd7);
    popBundle();
    popBundle();
    popBundle();
    checkOutput("wrap tail pc", 64'(bus.out_uop[0].pc), 64'h424);
    checkOutput("wrap tail count", 64'(bus.count), 64'd1);
    popBundle();

    // Flush with a simultaneous push.
    for (int i = 0; i < 5; i++) begin
      pushInsn(ADDI2, 32'h480 + 32'(i * 4), 1'b0);
    end
    checkOutput("preflush count", 64'(bus.count), 64'd5);
    applyStimulus(1'b1, ADDI3, 32'h999, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("flush count", 64'(bus.count), 64'd0);
    checkOutput("flush valid", 64'(bus.out_valid), 64'd0);
    pushInsn(ADDI1, 32'h500, 1'b0);
    checkOutput("postflush pc", 64'(bus.out_uop[0].pc), 64'h500);
    checkOutput("postflush count", 64'(bus.count), 64'd1);

    // Reset mid-operation with out_ready high.
    pushInsn(ADDI1, 32'h504, 1'b0);
    pushInsn(ADDI1, 32'h508, 1'b0);
    pushInsn(ADDI1, 32'h50c, 1'b0);
    checkOutput("prereset count", 64'(bus.count), 64'd4);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("midreset count", 64'(bus.count), 64'd0);
    checkOutput("midreset valid", 64'(bus.out_valid), 64'd0);
    checkOutput("midreset in_ready", 64'(bus.in_ready), 64'd1);
    pushInsn(ADDI2, 32'h600, 1'b0);
    checkOutput("postreset pc", 64'(bus.out_uop[0].pc), 64'h600);
    checkOutput("postreset count", 64'(bus.count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
